// File: rtl/jtpopeye_dma_ctrl_if.sv
// Sprite DMA sequencer bundle: timing/CPU enables, Z80 BUSRQ/BUSAK and buffer RAM strobes.
// master = sequencer side, slave = surrounding timing/CPU/RAM side.
interface jtpopeye_dma_ctrl_if;
   logic       cpu_cen;
   logic       pxl_cen;
   logic       VB;
   logic       busak_n;
   logic       busrq_n;
   logic       dma_cs;
   logic [9:0] dma_addr;
   logic       dma_we;
   logic [9:0] dma_waddr;
   logic       buf_sel;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      input  cpu_cen, pxl_cen, VB, busak_n,
      output busrq_n, dma_cs, dma_addr, dma_we, dma_waddr, buf_sel, busy, done, err
   );

   modport slave (
      output cpu_cen, pxl_cen, VB, busak_n,
      input  busrq_n, dma_cs, dma_addr, dma_we, dma_waddr, buf_sel, busy, done, err
   );
endinterface

// File: rtl/jtpopeye_dma_ctrl.sv
// Per-frame sprite DMA: VB rise -> BUSRQ -> LEN reads + 1-slot-delayed writes -> release, flip bank.
// Paced by pxl_cen, handshake on cpu_cen; JTPOPEYE_DMA_TIMEOUT_EN adds the BUSAK timeout/err path.
module jtpopeye_dma_ctrl #(
   parameter logic [9:0]  LEN  = 10'd768,
   parameter logic [11:0] TOUT = 12'd4095
)(
   input logic                 clk,
   input logic                 rst,
   jtpopeye_dma_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

   state_t     st;
   logic       vb_l;
   logic       first;
   logic       rd_last;
   logic [9:0] rd_addr;
   logic       start;
   logic       aborted;

   assign start = bus.VB & ~vb_l;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   logic [11:0] tcnt;
   logic        tout_frame;
   logic        err_r;

   assign bus.err = err_r;
   assign aborted = tout_frame;
`else
   assign bus.err = 1'b0;
   assign aborted = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= IDLE;
         vb_l          <= 1'b0;
         first         <= 1'b0;
         rd_last       <= 1'b0;
         rd_addr       <= 10'd0;
         bus.busrq_n   <= 1'b1;
         bus.dma_cs    <= 1'b0;
         bus.dma_addr  <= 10'd0;
         bus.dma_we    <= 1'b0;
         bus.dma_waddr <= 10'd0;
         bus.buf_sel   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
         tcnt          <= 12'd0;
         tout_frame    <= 1'b0;
         err_r         <= 1'b0;
`endif
      end else begin
         vb_l       <= bus.VB;
         bus.dma_we <= 1'b0;
         bus.done   <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  st          <= REQ;
                  bus.busrq_n <= 1'b0;
                  bus.busy    <= 1'b1;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                  tcnt        <= 12'd0;
                  tout_frame  <= 1'b0;
`endif
               end
            end
            REQ: begin
               if (bus.cpu_cen) begin
                  if (!bus.busak_n) begin
                     st           <= XFER;
                     bus.dma_cs   <= 1'b1;
                     bus.dma_addr <= 10'd0;
                     first        <= 1'b1;
                     rd_last      <= 1'b0;
                  end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                  else if (tcnt != TOUT) begin
                     tcnt <= tcnt + 12'd1;
                     if (tcnt + 12'd1 == TOUT) begin
                        st          <= REL;
                        bus.busrq_n <= 1'b1;
                        err_r       <= 1'b1;
                        tout_frame  <= 1'b1;
                     end
                  end
`endif
               end
            end
            XFER: begin
               if (bus.pxl_cen) begin
                  // write lags the read by one pxl_cen, matching the RAM read latency
                  if (!first) begin
                     bus.dma_we    <= 1'b1;
                     bus.dma_waddr <= rd_addr;
                  end
                  first <= 1'b0;
                  if (rd_last) begin
                     st          <= REL;
                     bus.dma_cs  <= 1'b0;
                     bus.busrq_n <= 1'b1;
                  end else begin
                     rd_addr <= bus.dma_addr;
                     if (bus.dma_addr == LEN - 10'd1)
                        rd_last <= 1'b1;
                     else
                        bus.dma_addr <= bus.dma_addr + 10'd1;
                  end
               end
            end
            REL: begin
               if (bus.cpu_cen && bus.busak_n) begin
                  st       <= IDLE;
                  bus.busy <= 1'b0;
                  if (!aborted) begin
                     bus.done    <= 1'b1;
                     bus.buf_sel <= ~bus.buf_sel;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                     err_r       <= 1'b0;
`endif
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtpopeye_dma_ctrl.sv
// Randomized frame-level bench for jtpopeye_dma_ctrl (LEN=4, TOUT=8) with a frame scoreboard.
module tb_jtpopeye_dma_ctrl;
   localparam logic [9:0]  LEN  = 10'd4;
   localparam logic [11:0] TOUT = 12'd8;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   jtpopeye_dma_ctrl_if bus();

   jtpopeye_dma_ctrl #(.LEN(LEN), .TOUT(TOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Z80 model: BUSAK follows BUSRQ one cpu_cen later when ack_en, else held high
   bit ack_en = 1'b1;
   initial begin
      bus.cpu_cen = 1'b0;
      bus.pxl_cen = 1'b0;
      bus.busak_n = 1'b1;
      forever begin
         @(negedge clk);
         if (!ack_en)
            bus.busak_n = 1'b1;
         else if (bus.cpu_cen)
            bus.busak_n = bus.busrq_n;
         bus.cpu_cen = ($urandom_range(0, 2) == 0);
         bus.pxl_cen = ($urandom_range(0, 1) == 0);
      end
   end

   // Frame observations
   logic [9:0] wq[$];
   logic [9:0] aq[$];
   int         done_cnt;
   int         rq_ticks;
   bit         cs_seen;
   logic       prev_cs, prev_rq;
   logic [9:0] prev_addr;
   logic       s_cpu, s_pxl;

   initial begin
      prev_cs = 1'b0; prev_rq = 1'b1; prev_addr = 10'd0;
      forever begin
         @(posedge clk);
         s_cpu = bus.cpu_cen;
         s_pxl = bus.pxl_cen;
         #1;
         if (rst) begin
            prev_cs = 1'b0; prev_rq = 1'b1; prev_addr = 10'd0;
         end else begin
            if (bus.dma_we) wq.push_back(bus.dma_waddr);
            if (bus.done) done_cnt++;
            if (bus.dma_cs) cs_seen = 1'b1;
            if (s_pxl && prev_cs) aq.push_back(prev_addr);
            if (s_cpu && !prev_rq) rq_ticks++;
            chk("addr_max", 32'(bus.dma_addr <= LEN - 10'd1), 1);
            if (!bus.busrq_n) chk("busy_rq", 32'(bus.busy), 1);
`ifndef JTPOPEYE_DMA_TIMEOUT_EN
            chk("err_tied", 32'(bus.err), 0);
`endif
            prev_cs = bus.dma_cs; prev_rq = bus.busrq_n; prev_addr = bus.dma_addr;
         end
      end
   end

   logic exp_buf = 1'b0;

   task automatic clear_obs();
      wq.delete(); aq.delete();
      done_cnt = 0; rq_ticks = 0; cs_seen = 1'b0;
   endtask

   task automatic run_frame(input bit ack, input bit dbl_vb);
      int guard;
      int vb_len;
      @(negedge clk);
      clear_obs();
      ack_en = ack;
      bus.VB = 1'b1;
      @(posedge clk); #1;
      chk("start_rq", 32'(bus.busrq_n), 0);
      chk("start_busy", 32'(bus.busy), 1);
      vb_len = $urandom_range(0, 2);
      repeat (vb_len) @(posedge clk);
      @(negedge clk) bus.VB = 1'b0;
      if (dbl_vb) begin
         @(negedge clk) bus.VB = 1'b1;
         @(posedge clk); #1;
         chk("dbl_busy", 32'(bus.busy), 1);
         @(negedge clk) bus.VB = 1'b0;
      end
      guard = 0;
      while (bus.busy && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("frame_end", 32'(guard < 3000), 1);
      @(negedge clk);
      chk("rq_idle", 32'(bus.busrq_n), 1);
      chk("cs_idle", 32'(bus.dma_cs), 0);
      if (ack) begin
         exp_buf = ~exp_buf;
         chk("we_cnt", 32'(wq.size()), 32'(LEN));
         for (int i = 0; i < wq.size() && i < int'(LEN); i++)
            chk("waddr", 32'(wq[i]), 32'(i));
         chk("slot_cnt", 32'(aq.size()), 32'(LEN) + 1);
         for (int i = 0; i < aq.size() && i < int'(LEN); i++)
            chk("raddr", 32'(aq[i]), 32'(i));
         chk("done_cnt", 32'(done_cnt), 1);
         chk("buf_sel", 32'(bus.buf_sel), 32'(exp_buf));
         chk("err_ok", 32'(bus.err), 0);
      end else begin
         chk("to_we", 32'(wq.size()), 0);
         chk("to_cs", 32'(cs_seen), 0);
         chk("to_done", 32'(done_cnt), 0);
         chk("to_buf", 32'(bus.buf_sel), 32'(exp_buf));
         chk("to_err", 32'(bus.err), 1);
         chk("to_ticks", 32'(rq_ticks), 32'(TOUT));
      end
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_mid_xfer();
      int guard;
      @(negedge clk);
      clear_obs();
      bus.VB = 1'b1;
      @(negedge clk) bus.VB = 1'b0;
      guard = 0;
      while (bus.dma_addr != 10'd2 && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reach_addr2", 32'(guard < 3000), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_rq", 32'(bus.busrq_n), 1);
      chk("rst_cs", 32'(bus.dma_cs), 0);
      chk("rst_addr", 32'(bus.dma_addr), 0);
      chk("rst_buf", 32'(bus.buf_sel), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_nodone", 32'(done_cnt), 0);
      chk("rst_buf2", 32'(bus.buf_sel), 0);
      chk("rst_idle", 32'(bus.busy), 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.VB = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("r_busrq_n", 32'(bus.busrq_n), 1);
      chk("r_dma_cs", 32'(bus.dma_cs), 0);
      chk("r_dma_addr", 32'(bus.dma_addr), 0);
      chk("r_dma_we", 32'(bus.dma_we), 0);
      chk("r_dma_waddr", 32'(bus.dma_waddr), 0);
      chk("r_buf_sel", 32'(bus.buf_sel), 0);
      chk("r_busy", 32'(bus.busy), 0);
      chk("r_done", 32'(bus.done), 0);
      chk("r_err", 32'(bus.err), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      reset_mid_xfer();
      exp_buf = 1'b0;

      // three consecutive frames: buf_sel 0->1->0->1
      for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b0);
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      run_frame(1'b0, 1'b0);
      run_frame(1'b1, 1'b0);
`endif
      // short VB plus a second rise while busy
      run_frame(1'b1, 1'b1);
      for (int f = 0; f < 4; f++) run_frame(1'b1, 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
